// File: rtl/lock_pkg.sv
// Shared definitions for the digital lock: keypad key codes and the
// entry-stage state encoding used by keypad_code_entry and the lock controlpath.
package lock_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_BKSP      = 4'hB;
    localparam logic [3:0] KEY_ENTER     = 4'hE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        PRESENT = 2'd2
    } entry_state_t;

    typedef enum logic [2:0] {
        KC_NONE  = 3'd0,
        KC_DIGIT = 3'd1,
        KC_CLEAR = 3'd2,
        KC_BKSP  = 3'd3,
        KC_ENTER = 3'd4
    } key_class_t;

    // Classify a raw key nibble; unassigned codes map to KC_NONE.
    function automatic key_class_t classify_key(input logic [3:0] key);
        key_class_t cls;
        if (key <= KEY_DIGIT_MAX)   cls = KC_DIGIT;
        else if (key == KEY_CLEAR)  cls = KC_CLEAR;
        else if (key == KEY_BKSP)   cls = KC_BKSP;
        else if (key == KEY_ENTER)  cls = KC_ENTER;
        else                        cls = KC_NONE;
        return cls;
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Inactivity timer for partial code entry. Down-counter holding the number of
// idle cycles still allowed; clear reloads it, enable decrements it, and expire
// flags the terminal count while enabled. With the default reload this fires
// on the TIMEOUT_CYC-th consecutive enabled cycle after a clear.
// Only instantiated when KEY_TIMEOUT_EN is defined.
module entry_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] remain_q;

    // Reload on clear/reset, count down while enabled, park at terminal count.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            remain_q <= TMR_LOAD;
        end else if (enable && (remain_q != '0)) begin
            remain_q <= remain_q - 1'b1;
        end
    end

    assign expire = enable && (remain_q == '0);

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad passcode assembler feeding the lock with a valid/ready handshake.
// Optional feature macro: KEY_TIMEOUT_EN (inactivity discard of partial entries).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no digits held; waits for the first digit
// ENTRY   | 1..DIGITS digits held; edit keys and ENTER are acted on
// PRESENT | full code offered on code_out with code_valid until ready
module keypad_code_entry
    import lock_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIGIT_W-1:0]            key_in,
    input  logic                          key_strobe,
    input  logic                          code_ready,
    output logic [DIGITS*DIGIT_W-1:0]     code_out,
    output logic                          code_valid,
    output logic [$clog2(DIGITS+1)-1:0]   digit_cnt,
    output logic                          short_err,
    output logic                          timeout_err
);

    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    entry_state_t       state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q;
    logic               short_q, short_d;
    logic [3:0]         key_nib;
    key_class_t         key_cls;

    // Key codes live in the low nibble of key_in.
    assign key_nib = 4'(key_in);
    assign key_cls = classify_key(key_nib);

`ifdef KEY_TIMEOUT_EN
    logic timer_expire;
    logic timeout_q, timeout_d;

    // The timer only runs in ENTRY; any key event or other state reloads it.
    entry_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_entry_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (key_strobe || (state_q != ENTRY)),
        .enable ((state_q == ENTRY) && !key_strobe),
        .expire (timer_expire)
    );
`endif

    // State and datapath registers; reset discards any held or presented code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
`ifdef KEY_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == PRESENT);
            short_q <= short_d;
`ifdef KEY_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state and next-datapath decode for one key event or handshake.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
`ifdef KEY_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (key_strobe && (key_cls == KC_DIGIT)) begin
                    code_d  = {code_q[CODE_W-DIGIT_W-1:0], key_in};
                    cnt_d   = CNT_ONE;
                    state_d = ENTRY;
                end
            end

            ENTRY: begin
                if (key_strobe) begin
                    case (key_cls)
                        KC_DIGIT: begin
                            // A full buffer ignores further digits rather than wrapping.
                            if (cnt_q < CNT_FULL) begin
                                code_d = {code_q[CODE_W-DIGIT_W-1:0], key_in};
                                cnt_d  = cnt_q + 1'b1;
                            end
                        end
                        KC_BKSP: begin
                            code_d = code_q >> DIGIT_W;
                            cnt_d  = cnt_q - 1'b1;
                            if (cnt_q == CNT_ONE) begin
                                state_d = IDLE;
                            end
                        end
                        KC_CLEAR: begin
                            code_d  = '0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                        KC_ENTER: begin
                            if (cnt_q == CNT_FULL) begin
                                state_d = PRESENT;
                            end else begin
                                short_d = 1'b1;
                                code_d  = '0;
                                cnt_d   = '0;
                                state_d = IDLE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
`ifdef KEY_TIMEOUT_EN
                else if (timer_expire) begin
                    timeout_d = 1'b1;
                    code_d    = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
`endif
            end

            PRESENT: begin
                // Keys are ignored here; only the lock accepting the code releases it.
                if (valid_q && code_ready) begin
                    code_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                code_d  = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign digit_cnt  = cnt_q;
    assign short_err  = short_q;

`ifdef KEY_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed bench for keypad_code_entry (DIGITS=4, DIGIT_W=4, TIMEOUT_CYC=16).
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that captured them.
module tb_keypad_code_entry;

    localparam int DIGITS      = 4;
    localparam int DIGIT_W     = 4;
    localparam int TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_in;
    logic        key_strobe;
    logic        code_ready;
    logic [15:0] code_out;
    logic        code_valid;
    logic [2:0]  digit_cnt;
    logic        short_err;
    logic        timeout_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    keypad_code_entry #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_strobe  (key_strobe),
        .code_ready  (code_ready),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .digit_cnt   (digit_cnt),
        .short_err   (short_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic press(input logic [3:0] k);
        key_in     = k;
        key_strobe = 1'b1;
        @(negedge clk);
        key_strobe = 1'b0;
        key_in     = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic accept();
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        vec_cnt++; if (code_out !== 16'h0000) begin $display("FAIL reset_code got %h exp 0000", code_out); err_cnt++; end
        vec_cnt++; if (code_valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", code_valid); err_cnt++; end
        vec_cnt++; if (digit_cnt !== 3'd0) begin $display("FAIL reset_cnt got %0d exp 0", digit_cnt); err_cnt++; end
        vec_cnt++; if (short_err !== 1'b0) begin $display("FAIL reset_short got %b exp 0", short_err); err_cnt++; end
        vec_cnt++; if (timeout_err !== 1'b0) begin $display("FAIL reset_timeout got %b exp 0", timeout_err); err_cnt++; end
        rst = 1'b0;
    endtask

    task automatic test_present_hold();
        press(4'h1); press(4'h0);
        accept();
        vec_cnt++; if (digit_cnt !== 3'd2 || code_out !== 16'h0010) begin $display("FAIL ready_ignored got cnt=%0d code=%h exp cnt=2 code=0010", digit_cnt, code_out); err_cnt++; end
        press(4'h0); press(4'h1);
        vec_cnt++; if (digit_cnt !== 3'd4 || code_out !== 16'h1001 || code_valid !== 1'b0) begin $display("FAIL full_1001 got cnt=%0d code=%h v=%b exp 4 1001 0", digit_cnt, code_out, code_valid); err_cnt++; end
        press(4'hE);
        vec_cnt++; if (code_valid !== 1'b1 || code_out !== 16'h1001) begin $display("FAIL enter_1001 got v=%b code=%h exp 1 1001", code_valid, code_out); err_cnt++; end
        idle(5);
        vec_cnt++; if (code_valid !== 1'b1 || code_out !== 16'h1001 || digit_cnt !== 3'd4) begin $display("FAIL hold_1001 got v=%b code=%h cnt=%0d exp 1 1001 4", code_valid, code_out, digit_cnt); err_cnt++; end
        accept();
        vec_cnt++; if (code_valid !== 1'b0 || digit_cnt !== 3'd0 || code_out !== 16'h0000) begin $display("FAIL release_1001 got v=%b cnt=%0d code=%h exp 0 0 0000", code_valid, digit_cnt, code_out); err_cnt++; end
    endtask

    task automatic test_backspace();
        press(4'h1); press(4'h2); press(4'hB);
        vec_cnt++; if (digit_cnt !== 3'd1 || code_out !== 16'h0001) begin $display("FAIL bksp_one got cnt=%0d code=%h exp 1 0001", digit_cnt, code_out); err_cnt++; end
        press(4'h3); press(4'h4); press(4'h5); press(4'hE);
        vec_cnt++; if (code_valid !== 1'b1 || code_out !== 16'h1345) begin $display("FAIL enter_1345 got v=%b code=%h exp 1 1345", code_valid, code_out); err_cnt++; end
        press(4'h9); press(4'hA); press(4'hB); press(4'hE);
        vec_cnt++; if (code_valid !== 1'b1 || code_out !== 16'h1345 || digit_cnt !== 3'd4) begin $display("FAIL present_frozen got v=%b code=%h cnt=%0d exp 1 1345 4", code_valid, code_out, digit_cnt); err_cnt++; end
        accept();
        vec_cnt++; if (code_valid !== 1'b0) begin $display("FAIL release_1345 got v=%b exp 0", code_valid); err_cnt++; end
        press(4'h5); press(4'hB);
        vec_cnt++; if (digit_cnt !== 3'd0 || code_out !== 16'h0000) begin $display("FAIL bksp_to_zero got cnt=%0d code=%h exp 0 0000", digit_cnt, code_out); err_cnt++; end
        press(4'hB); press(4'hE);
        vec_cnt++; if (short_err !== 1'b0 || digit_cnt !== 3'd0) begin $display("FAIL idle_enter got short=%b cnt=%0d exp 0 0", short_err, digit_cnt); err_cnt++; end
    endtask

    task automatic test_short_err();
        press(4'h7); press(4'h8); press(4'hE);
        vec_cnt++; if (short_err !== 1'b1) begin $display("FAIL short_pulse got %b exp 1", short_err); err_cnt++; end
        vec_cnt++; if (digit_cnt !== 3'd0 || code_out !== 16'h0000 || code_valid !== 1'b0) begin $display("FAIL short_clear got cnt=%0d code=%h v=%b exp 0 0000 0", digit_cnt, code_out, code_valid); err_cnt++; end
        idle(1);
        vec_cnt++; if (short_err !== 1'b0) begin $display("FAIL short_width got %b exp 0", short_err); err_cnt++; end
    endtask

    task automatic test_overflow();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'h6);
        vec_cnt++; if (digit_cnt !== 3'd4 || code_out !== 16'h1234) begin $display("FAIL overflow got cnt=%0d code=%h exp 4 1234", digit_cnt, code_out); err_cnt++; end
        press(4'hE);
        vec_cnt++; if (code_valid !== 1'b1 || code_out !== 16'h1234) begin $display("FAIL enter_1234 got v=%b code=%h exp 1 1234", code_valid, code_out); err_cnt++; end
        accept();
        press(4'h3); press(4'h4); press(4'hA);
        vec_cnt++; if (digit_cnt !== 3'd0 || code_out !== 16'h0000 || short_err !== 1'b0) begin $display("FAIL clear got cnt=%0d code=%h short=%b exp 0 0000 0", digit_cnt, code_out, short_err); err_cnt++; end
        press(4'hB);
        vec_cnt++; if (digit_cnt !== 3'd0) begin $display("FAIL idle_bksp got cnt=%0d exp 0", digit_cnt); err_cnt++; end
        press(4'h9);
        vec_cnt++; if (digit_cnt !== 3'd1 || code_out !== 16'h0009) begin $display("FAIL after_clear got cnt=%0d code=%h exp 1 0009", digit_cnt, code_out); err_cnt++; end
        press(4'hA);
    endtask

    task automatic test_reset_mid();
        press(4'h1); press(4'h2); press(4'h3);
        vec_cnt++; if (digit_cnt !== 3'd3) begin $display("FAIL pre_rst_cnt got %0d exp 3", digit_cnt); err_cnt++; end
        rst = 1'b1; key_in = 4'h4; key_strobe = 1'b1;
        idle(1);
        rst = 1'b0; key_strobe = 1'b0; key_in = 4'h0;
        vec_cnt++; if (digit_cnt !== 3'd0 || code_out !== 16'h0000 || code_valid !== 1'b0 || short_err !== 1'b0) begin $display("FAIL rst_entry got cnt=%0d code=%h v=%b short=%b exp 0 0000 0 0", digit_cnt, code_out, code_valid, short_err); err_cnt++; end
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hE);
        vec_cnt++; if (code_valid !== 1'b1) begin $display("FAIL pre_rst_valid got %b exp 1", code_valid); err_cnt++; end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        vec_cnt++; if (digit_cnt !== 3'd0 || code_out !== 16'h0000 || code_valid !== 1'b0 || timeout_err !== 1'b0) begin $display("FAIL rst_present got cnt=%0d code=%h v=%b to=%b exp 0 0000 0 0", digit_cnt, code_out, code_valid, timeout_err); err_cnt++; end
        idle(1);
        vec_cnt++; if (code_valid !== 1'b0) begin $display("FAIL post_rst_valid got %b exp 0", code_valid); err_cnt++; end
    endtask

`ifdef KEY_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        press(4'h4); press(4'h2);
        idle(TIMEOUT_CYC - 1);
        vec_cnt++; if (timeout_err !== 1'b0 || digit_cnt !== 3'd2) begin $display("FAIL pre_expiry got to=%b cnt=%0d exp 0 2", timeout_err, digit_cnt); err_cnt++; end
        idle(1);
        vec_cnt++; if (timeout_err !== 1'b1 || digit_cnt !== 3'd0 || code_out !== 16'h0000) begin $display("FAIL expiry got to=%b cnt=%0d code=%h exp 1 0 0000", timeout_err, digit_cnt, code_out); err_cnt++; end
        idle(1);
        vec_cnt++; if (timeout_err !== 1'b0) begin $display("FAIL expiry_width got %b exp 0", timeout_err); err_cnt++; end
        press(4'h4); press(4'h2);
        idle(TIMEOUT_CYC - 1);
        press(4'h3);
        vec_cnt++; if (timeout_err !== 1'b0 || digit_cnt !== 3'd3 || code_out !== 16'h0423) begin $display("FAIL key_wins got to=%b cnt=%0d code=%h exp 0 3 0423", timeout_err, digit_cnt, code_out); err_cnt++; end
        idle(TIMEOUT_CYC);
        vec_cnt++; if (timeout_err !== 1'b1 || digit_cnt !== 3'd0) begin $display("FAIL reload_expiry got to=%b cnt=%0d exp 1 0", timeout_err, digit_cnt); err_cnt++; end
        press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'hE);
        seen = 1'b0;
        for (int i = 0; i < 3 * TIMEOUT_CYC; i++) begin
            @(negedge clk);
            if (timeout_err) seen = 1'b1;
        end
        vec_cnt++; if (seen !== 1'b0 || code_valid !== 1'b1 || code_out !== 16'h5678) begin $display("FAIL present_no_timeout got seen=%b v=%b code=%h exp 0 1 5678", seen, code_valid, code_out); err_cnt++; end
        accept();
    endtask
`else
    task automatic test_timeout();
        bit seen;
        press(4'h4); press(4'h2);
        seen = 1'b0;
        for (int i = 0; i < 3 * TIMEOUT_CYC; i++) begin
            @(negedge clk);
            if (timeout_err) seen = 1'b1;
        end
        vec_cnt++; if (seen !== 1'b0) begin $display("FAIL no_timeout got seen=%b exp 0", seen); err_cnt++; end
        vec_cnt++; if (digit_cnt !== 3'd2 || code_out !== 16'h0042) begin $display("FAIL persist got cnt=%0d code=%h exp 2 0042", digit_cnt, code_out); err_cnt++; end
        press(4'hA);
    endtask
`endif

    initial begin
        rst        = 1'b1;
        key_in     = 4'h0;
        key_strobe = 1'b0;
        code_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_present_hold();
        test_backspace();
        test_short_err();
        test_overflow();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got time %0t exp bench end", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
